// File: rtl/mc_ctrl_if.sv
// Instruction-source and data-memory handshake bundle for the multi-cycle controller.
// master = controller side, slave = instruction source / data memory side.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;

  modport master (
    input  instr,
    input  instr_valid,
    input  mem_ack,
    output instr_ready,
    output mem_req,
    output mem_we
  );

  modport slave (
    output instr,
    output instr_valid,
    output mem_ack,
    input  instr_ready,
    input  mem_req,
    input  mem_we
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the P-series MIPS datapath.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | accept next instruction word, bump PC by 4
// DECODE | classify ir; j/nop/illegal finish here
// EXEC   | drive ALU; beq resolves branch and finishes here
// MEM    | hold data memory request until ack or timeout
// WB     | write register file, then return to FETCH
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  mc_ctrl_if.master   mc_bus,
  input  logic        i_zero,
  output logic [1:0]  o_eop,
  output logic [1:0]  o_alu_op,
  output logic        o_alu_src,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_src,
  output logic        o_reg_we,
  output logic        o_reg_dst,
  output logic        o_wb_sel,
  output logic        o_illegal,
  output logic        o_mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Wait budget is kept as remaining cycles; zero means this is the last MEM cycle.
  localparam logic [7:0] CNT_LOAD = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_ir;
  logic [7:0]  r_cnt;
  logic        r_illegal;
  logic        r_mem_err;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic        w_addu, w_subu, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_nop, w_bad;
  logic [1:0]  w_eop;
  logic [1:0]  w_alu_op;
  logic        w_alu_src;
  logic        w_unused_ir;

  assign w_op        = r_ir[31:26];
  assign w_fn        = r_ir[5:0];
  assign w_unused_ir = ^r_ir[25:6];

  assign w_addu = (w_op == 6'h00) && (w_fn == 6'h21);
  assign w_subu = (w_op == 6'h00) && (w_fn == 6'h23);
  assign w_ori  = (w_op == 6'h0D);
  assign w_lui  = (w_op == 6'h0F);
  assign w_lw   = (w_op == 6'h23);
  assign w_sw   = (w_op == 6'h2B);
  assign w_beq  = (w_op == 6'h04);
  assign w_j    = (w_op == 6'h02);
  assign w_nop  = (r_ir == 32'h0000_0000);
  // A zero opcode with a funct other than addu/subu is unsupported unless the whole word is zero.
  assign w_bad  = !(w_addu || w_subu || w_ori || w_lui || w_lw || w_sw || w_beq || w_j || w_nop);

  assign w_eop     = w_ori ? 2'b01 : (w_lui ? 2'b10 : 2'b00);
  assign w_alu_op  = (w_subu || w_beq) ? 2'b01 :
                     w_ori             ? 2'b10 :
                     w_lui             ? 2'b11 : 2'b00;
  assign w_alu_src = w_ori || w_lui || w_lw || w_sw;

  // State, instruction register, MEM wait counter and the two error pulses.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (mc_bus.instr_valid) begin
            r_ir    <= mc_bus.instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_j || w_nop) begin
            r_state <= S_FETCH;
          end else if (w_bad) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_beq) begin
            r_state <= S_FETCH;
          end else if (w_lw || w_sw) begin
            r_state <= S_MEM;
            r_cnt   <= CNT_LOAD;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mc_bus.mem_ack) begin
            r_state <= w_lw ? S_WB : S_FETCH;
          end else if (r_cnt == 8'd0) begin
            r_state   <= S_FETCH;
            r_mem_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Datapath controls decoded from state and ir; everything defaults to 0.
  always_comb begin
    mc_bus.instr_ready = 1'b0;
    mc_bus.mem_req     = 1'b0;
    mc_bus.mem_we      = 1'b0;
    o_eop              = 2'b00;
    o_alu_op           = 2'b00;
    o_alu_src          = 1'b0;
    o_pc_we            = 1'b0;
    o_pc_src           = 2'b00;
    o_reg_we           = 1'b0;
    o_reg_dst          = 1'b0;
    o_wb_sel           = 1'b0;
    case (r_state)
      S_FETCH: begin
        mc_bus.instr_ready = 1'b1;
        o_pc_we            = mc_bus.instr_valid;
      end
      S_DECODE: begin
        o_eop = w_eop;
        if (w_j) begin
          o_pc_we  = 1'b1;
          o_pc_src = 2'b10;
        end
      end
      S_EXEC: begin
        o_eop     = w_eop;
        o_alu_op  = w_alu_op;
        o_alu_src = w_alu_src;
        if (w_beq) begin
          o_pc_we  = i_zero;
          o_pc_src = 2'b01;
        end
      end
      S_MEM: begin
        mc_bus.mem_req = 1'b1;
        mc_bus.mem_we  = w_sw;
      end
      S_WB: begin
        o_eop     = w_eop;
        o_alu_op  = w_alu_op;
        o_alu_src = w_alu_src;
        o_reg_we  = 1'b1;
        o_reg_dst = w_addu || w_subu;
        o_wb_sel  = w_lw;
      end
      default: begin
        mc_bus.instr_ready = 1'b0;
      end
    endcase
  end

  assign o_illegal = r_illegal;
  assign o_mem_err = r_mem_err;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver pushes the expected control vector for each
// cycle it drives, a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_ctrl;

  localparam logic [15:0] NONE   = 16'h0000;
  localparam logic [15:0] RDY    = 16'h8000;
  localparam logic [15:0] PCWE   = 16'h4000;
  localparam logic [15:0] PCS_J  = 16'h2000;
  localparam logic [15:0] PCS_BR = 16'h1000;
  localparam logic [15:0] EOP_L  = 16'h0800;
  localparam logic [15:0] EOP_Z  = 16'h0400;
  localparam logic [15:0] AOP_OR = 16'h0200;
  localparam logic [15:0] AOP_SB = 16'h0100;
  localparam logic [15:0] AOP_B  = 16'h0300;
  localparam logic [15:0] ASRC   = 16'h0080;
  localparam logic [15:0] RWE    = 16'h0040;
  localparam logic [15:0] RDST   = 16'h0020;
  localparam logic [15:0] WBS    = 16'h0010;
  localparam logic [15:0] MREQ   = 16'h0008;
  localparam logic [15:0] MWE    = 16'h0004;
  localparam logic [15:0] ILL    = 16'h0002;
  localparam logic [15:0] MERR   = 16'h0001;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        zero;
  logic [1:0]  eop, alu_op, pc_src;
  logic        alu_src, pc_we, reg_we, reg_dst, wb_sel, illegal, mem_err;
  logic [15:0] w_obs;
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;

  mc_ctrl_if bus ();

  mc_ctrl #(.MEM_TIMEOUT(15)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .mc_bus    (bus.master),
    .i_zero    (zero),
    .o_eop     (eop),
    .o_alu_op  (alu_op),
    .o_alu_src (alu_src),
    .o_pc_we   (pc_we),
    .o_pc_src  (pc_src),
    .o_reg_we  (reg_we),
    .o_reg_dst (reg_dst),
    .o_wb_sel  (wb_sel),
    .o_illegal (illegal),
    .o_mem_err (mem_err)
  );

  always #5 clk = ~clk;

  assign w_obs = {bus.instr_ready, pc_we, pc_src, eop, alu_op, alu_src,
                  reg_we, reg_dst, wb_sel, bus.mem_req, bus.mem_we, illegal, mem_err};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, w_obs, e.v);
    end
  end

  task automatic cyc(input string tag, input logic rst, input logic vld, input logic [31:0] w,
                     input logic z, input logic ack, input logic [15:0] e);
    exp_t x;
    reset           = rst;
    bus.instr_valid = vld;
    bus.instr       = w;
    zero            = z;
    bus.mem_ack     = ack;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic fe(input string tag, input logic [31:0] w);
    cyc(tag, 1'b1, 1'b1, w, 1'b0, 1'b0, RDY | PCWE);
  endtask

  task automatic st(input string tag, input logic [15:0] e);
    cyc(tag, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, e);
  endtask

  task automatic sta(input string tag, input logic ack, input logic [15:0] e);
    cyc(tag, 1'b1, 1'b0, 32'h0, 1'b0, ack, e);
  endtask

  initial begin
    int k;
    reset = 1'b0;
    zero = 1'b0;
    bus.instr = 32'h0;
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst_a", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, RDY);
    st("idle", RDY);

    // ori with a stray word offered outside FETCH; it must be ignored
    fe("ori_F", 32'h3421_00FF);
    cyc("ori_D", 1'b1, 1'b1, 32'h3C01_1234, 1'b0, 1'b0, EOP_Z);
    cyc("ori_E", 1'b1, 1'b1, 32'h3C01_1234, 1'b0, 1'b0, EOP_Z | AOP_OR | ASRC);
    cyc("ori_W", 1'b1, 1'b1, 32'h3C01_1234, 1'b0, 1'b0, EOP_Z | AOP_OR | ASRC | RWE);
    st("ori_end", RDY);

    fe("addu_F", 32'h0022_1821);
    st("addu_D", NONE);
    st("addu_E", NONE);
    st("addu_W", RWE | RDST);
    fe("subu_F", 32'h0022_1823);
    st("subu_D", NONE);
    st("subu_E", AOP_SB);
    st("subu_W", AOP_SB | RWE | RDST);
    fe("lui_F", 32'h3C01_1234);
    st("lui_D", EOP_L);
    st("lui_E", EOP_L | AOP_B | ASRC);
    st("lui_W", EOP_L | AOP_B | ASRC | RWE);
    st("lui_end", RDY);

    // lw acked on third MEM cycle: 7 cycles in total
    fe("lw_F", 32'h8C01_0004);
    st("lw_D", NONE);
    st("lw_E", ASRC);
    sta("lw_M1", 1'b0, MREQ);
    sta("lw_M2", 1'b0, MREQ);
    sta("lw_M3", 1'b1, MREQ);
    st("lw_W", ASRC | RWE | WBS);
    st("lw_end", RDY);

    fe("sw_F", 32'hAC01_0004);
    st("sw_D", NONE);
    st("sw_E", ASRC);
    sta("sw_M1", 1'b1, MREQ | MWE);
    st("sw_end", RDY);

    // sw never acked: 15 MEM cycles, then a single mem_err pulse, no register write
    fe("swto_F", 32'hAC01_0004);
    st("swto_D", NONE);
    st("swto_E", ASRC);
    for (int i = 0; i < 15; i++) sta($sformatf("swto_M%0d", i + 1), 1'b0, MREQ | MWE);
    st("swto_err", RDY | MERR);
    st("swto_end", RDY);

    // ack arriving on the last allowed cycle is a success
    fe("swl_F", 32'hAC01_0004);
    st("swl_D", NONE);
    st("swl_E", ASRC);
    for (int i = 0; i < 14; i++) sta($sformatf("swl_M%0d", i + 1), 1'b0, MREQ | MWE);
    sta("swl_M15", 1'b1, MREQ | MWE);
    st("swl_end", RDY);

    fe("lwl_F", 32'h8C01_0004);
    st("lwl_D", NONE);
    st("lwl_E", ASRC);
    for (int i = 0; i < 14; i++) sta($sformatf("lwl_M%0d", i + 1), 1'b0, MREQ);
    sta("lwl_M15", 1'b1, MREQ);
    st("lwl_W", ASRC | RWE | WBS);
    st("lwl_end", RDY);

    fe("beq1_F", 32'h1022_FFFF);
    st("beq1_D", NONE);
    cyc("beq1_E", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, PCWE | PCS_BR | AOP_SB);
    st("beq1_end", RDY);
    fe("beq0_F", 32'h1022_FFFF);
    st("beq0_D", NONE);
    cyc("beq0_E", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, PCS_BR | AOP_SB);
    st("beq0_end", RDY);

    fe("ill_F", 32'hFC00_0000);
    st("ill_D", NONE);
    st("ill_pulse", RDY | ILL);
    st("ill_end", RDY);
    fe("sll_F", 32'h0000_0040);
    st("sll_D", NONE);
    st("sll_pulse", RDY | ILL);
    st("sll_end", RDY);

    fe("j_F", 32'h0800_0010);
    st("j_D", PCWE | PCS_J);
    st("j_end", RDY);
    fe("nop_F", 32'h0000_0000);
    st("nop_D", NONE);
    st("nop_end", RDY);

    // reset held two cycles while waiting in MEM aborts the store
    fe("rsw_F", 32'hAC01_0004);
    st("rsw_D", NONE);
    st("rsw_E", ASRC);
    for (int i = 0; i < 3; i++) sta($sformatf("rsw_M%0d", i + 1), 1'b0, MREQ | MWE);
    cyc("rsw_r1", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, MREQ | MWE);
    cyc("rsw_r2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, RDY);
    st("rsw_post1", RDY);
    st("rsw_post2", RDY);

    k = 0;
    while (sb.size() != 0 && k < 5) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
